// File: rtl/bsg_fifo_rolly_pkg.sv
// Shared types and constants for the rolly FIFO write-side packet controller.
//   state_e          : packet FSM states
//   sat_cnt_width_gp : width of the packet statistics counters
package bsg_fifo_rolly_pkg;

  typedef enum logic {
    e_recv,
    e_discard
  } state_e;

  localparam int sat_cnt_width_gp = 16;

endpackage

// File: rtl/bsg_fifo_rolly_packet_enq_if.sv
// Upstream beat stream into the packet enqueue controller.
//   v_i     : beat valid (producer -> controller)
//   data_i  : beat payload
//   last_i  : final beat of packet
//   err_i   : packet is bad, qualified by v_i
//   ready_o : controller accepts the beat when v_i & ready_o
// Signal names are from the controller's point of view.
interface bsg_fifo_rolly_packet_enq_if #(parameter int width_p = 8);

  logic               v_i;
  logic [width_p-1:0] data_i;
  logic               last_i;
  logic               err_i;
  logic               ready_o;

  modport master (output v_i, output data_i, output last_i, output err_i, input ready_o);
  modport slave  (input v_i, input data_i, input last_i, input err_i, output ready_o);

endinterface

// File: rtl/bsg_counter_sat_en.sv
// Saturating up-counter with enable.
//   clk_i   : clock
//   reset_i : synchronous active-high reset, clears the count
//   en_i    : increment this cycle
//   count_o : current count, sticks at all-ones
module bsg_counter_sat_en
  import bsg_fifo_rolly_pkg::*;
#(
  parameter int width_p = sat_cnt_width_gp
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i)
      count_o <= '0;
    else if (en_i && (count_o != '1))
      count_o <= count_o + width_p'(1);
  end

endmodule

// File: rtl/bsg_fifo_rolly_packet_enq.sv
// Write-side packet controller for the rolly FIFO. Accepts a beat stream,
// writes beats into the FIFO and commits whole good packets atomically;
// bad, oversize or flushed packets are dropped so the reader never sees them.
//   clk_i, reset_i     : clock, synchronous active-high reset
//   in_if              : upstream beat stream (slave side)
//   flush_i            : abort the in-progress packet
//   full_i             : tracker full
//   enq_o              : write w_data_o at the tracker write pointer
//   commit_o / drop_o  : tracker commit / drop of the pending packet
//   w_data_o           : FIFO memory write data (passthrough of data_i)
//   pkt_commit_cnt_o   : committed packets, saturating
//   pkt_drop_cnt_o     : dropped packets (any cause), saturating
//
// state     | meaning
// ----------+---------------------------------------------------------
// e_recv    | receiving; cnt_r beats of current packet written (0 = idle)
// e_discard | swallowing the rest of a dropped packet up to its last beat
module bsg_fifo_rolly_packet_enq
  import bsg_fifo_rolly_pkg::*;
#(
  parameter int width_p   = 8,
  parameter int lg_size_p = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  bsg_fifo_rolly_packet_enq_if.slave  in_if,
  input  logic                        flush_i,
  input  logic                        full_i,
  output logic                        enq_o,
  output logic                        commit_o,
  output logic                        drop_o,
  output logic [width_p-1:0]          w_data_o,
  output logic [sat_cnt_width_gp-1:0] pkt_commit_cnt_o,
  output logic [sat_cnt_width_gp-1:0] pkt_drop_cnt_o
);

  localparam int els_lp   = 1 << lg_size_p;
  localparam int cnt_w_lp = lg_size_p + 1;

  state_e              state_r, state_n;
  logic [cnt_w_lp-1:0] cnt_r, cnt_n;
  logic                oversize;
  logic                ready;

  assign oversize = (cnt_r == cnt_w_lp'(els_lp));
  assign w_data_o = in_if.data_i;
  assign in_if.ready_o = ready;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_recv;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    ready    = 1'b0;
    enq_o    = 1'b0;
    commit_o = 1'b0;
    drop_o   = 1'b0;

    case (state_r)
      e_recv: begin
        if (flush_i) begin
          if (cnt_r != '0) begin
            drop_o  = 1'b1;
            cnt_n   = '0;
            state_n = e_discard;
          end
        end else begin
          // An oversize packet is dropped regardless of full: nothing is
          // written, so there is no reason to stall the producer.
          ready = ~full_i | oversize;
          if (in_if.v_i && ready) begin
            if (in_if.err_i || oversize) begin
              drop_o  = 1'b1;
              cnt_n   = '0;
              state_n = in_if.last_i ? e_recv : e_discard;
            end else if (in_if.last_i) begin
              // commit covers the beat written in this same cycle
              enq_o    = 1'b1;
              commit_o = 1'b1;
              cnt_n    = '0;
            end else begin
              enq_o = 1'b1;
              cnt_n = cnt_r + cnt_w_lp'(1);
            end
          end
        end
      end
      default: begin
        if (!flush_i) begin
          ready = 1'b1;
          if (in_if.v_i && in_if.last_i)
            state_n = e_recv;
        end
      end
    endcase
  end

  bsg_counter_sat_en #(.width_p(sat_cnt_width_gp)) commit_ctr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (commit_o),
    .count_o (pkt_commit_cnt_o)
  );

  bsg_counter_sat_en #(.width_p(sat_cnt_width_gp)) drop_ctr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (drop_o),
    .count_o (pkt_drop_cnt_o)
  );

endmodule

// File: tb/tb_bsg_fifo_rolly_packet_enq.sv
// Directed + random bench for bsg_fifo_rolly_packet_enq (width 8, depth 4).
module tb_bsg_fifo_rolly_packet_enq;
  import bsg_fifo_rolly_pkg::*;

  typedef struct packed {
    logic [3:0] ctl;   // {ready, enq, commit, drop}
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        flush_i, full_i;
  logic        enq_o, commit_o, drop_o;
  logic [7:0]  w_data_o;
  logic [15:0] pkt_commit_cnt_o, pkt_drop_cnt_o;

  int   passed = 0;
  int   total  = 0;
  exp_t sb[$];
  logic [7:0] dval = 8'h00;

  bsg_fifo_rolly_packet_enq_if #(.width_p(8)) bus ();

  bsg_fifo_rolly_packet_enq #(.width_p(8), .lg_size_p(2)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .in_if            (bus),
    .flush_i          (flush_i),
    .full_i           (full_i),
    .enq_o            (enq_o),
    .commit_o         (commit_o),
    .drop_o           (drop_o),
    .w_data_o         (w_data_o),
    .pkt_commit_cnt_o (pkt_commit_cnt_o),
    .pkt_drop_cnt_o   (pkt_drop_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called just after a posedge; drives one cycle, checks at negedge.
  task automatic step(input string tag, input logic v, input logic last, input logic err,
                      input logic flush, input logic full, input logic [3:0] ctl);
    exp_t e;
    dval = dval + 8'd1;
    bus.v_i = v; bus.data_i = dval; bus.last_i = last; bus.err_i = err;
    flush_i = flush; full_i = full;
    e.ctl = ctl; e.data = dval;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, "_ctl"}, {28'd0, bus.ready_o, enq_o, commit_o, drop_o}, {28'd0, e.ctl});
    if (e.ctl[2]) chk({tag, "_wdata"}, {24'd0, w_data_o}, {24'd0, e.data});
    @(posedge clk); #1;
    bus.v_i = 1'b0; bus.last_i = 1'b0; bus.err_i = 1'b0; flush_i = 1'b0; full_i = 1'b0;
  endtask

  localparam logic [3:0] ENQ = 4'b1100, CMT = 4'b1110, DRP = 4'b1001, ACC = 4'b1000,
                         STL = 4'b0000, FDR = 4'b0001;

  initial begin
    int bad, v1, v2, v3;
    reset_i = 1'b1; flush_i = 1'b0; full_i = 1'b0;
    bus.v_i = 1'b0; bus.data_i = '0; bus.last_i = 1'b0; bus.err_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", {28'd0, bus.ready_o, enq_o, commit_o, drop_o}, 32'h8);
    chk("reset_ccnt", {16'd0, pkt_commit_cnt_o}, 32'd0);
    chk("reset_dcnt", {16'd0, pkt_drop_cnt_o}, 32'd0);
    full_i = 1'b1; #1;
    chk("reset_full_ready", {31'd0, bus.ready_o}, 32'd0);
    full_i = 1'b0;
    @(posedge clk); #1; reset_i = 1'b0;

    // 3-beat good packet
    step("p3_b1", 1, 0, 0, 0, 0, ENQ);
    step("p3_b2", 1, 0, 0, 0, 0, ENQ);
    chk("p3_ccnt_pre", {16'd0, pkt_commit_cnt_o}, 32'd0);
    step("p3_b3", 1, 1, 0, 0, 0, CMT);
    chk("p3_ccnt", {16'd0, pkt_commit_cnt_o}, 32'd1);

    // error on beat 2 of 4
    step("err_b1", 1, 0, 0, 0, 0, ENQ);
    step("err_b2", 1, 0, 1, 0, 0, DRP);
    chk("err_dcnt", {16'd0, pkt_drop_cnt_o}, 32'd1);
    step("err_b3", 1, 0, 0, 0, 0, ACC);
    step("err_b4", 1, 1, 0, 0, 0, ACC);
    step("err_next", 1, 1, 0, 0, 0, CMT);
    chk("err_ccnt", {16'd0, pkt_commit_cnt_o}, 32'd2);

    // 6-beat packet into depth 4: oversize drop despite full
    step("ovs_b1", 1, 0, 0, 0, 0, ENQ);
    step("ovs_b2", 1, 0, 0, 0, 0, ENQ);
    step("ovs_b3", 1, 0, 0, 0, 0, ENQ);
    step("ovs_b4", 1, 0, 0, 0, 0, ENQ);
    step("ovs_b5", 1, 0, 0, 0, 1, DRP);
    step("ovs_b6", 1, 1, 0, 0, 1, ACC);
    chk("ovs_dcnt", {16'd0, pkt_drop_cnt_o}, 32'd2);
    chk("ovs_ccnt", {16'd0, pkt_commit_cnt_o}, 32'd2);

    // exactly 4 beats with full held 2 cycles mid-packet
    step("p4_b1", 1, 0, 0, 0, 0, ENQ);
    step("p4_b2", 1, 0, 0, 0, 0, ENQ);
    step("p4_full1", 1, 0, 0, 0, 1, STL);
    step("p4_full2", 1, 0, 0, 0, 1, STL);
    step("p4_b3", 1, 0, 0, 0, 0, ENQ);
    step("p4_b4", 1, 1, 0, 0, 0, CMT);
    chk("p4_ccnt", {16'd0, pkt_commit_cnt_o}, 32'd3);

    // flush after 2 beats, then flush while idle
    step("fl_b1", 1, 0, 0, 0, 0, ENQ);
    step("fl_b2", 1, 0, 0, 0, 0, ENQ);
    step("fl_flush", 1, 0, 0, 1, 0, FDR);
    step("fl_b3", 1, 0, 0, 0, 0, ACC);
    step("fl_disc_flush", 1, 1, 0, 1, 0, STL);
    step("fl_b4", 1, 1, 0, 0, 0, ACC);
    chk("fl_dcnt", {16'd0, pkt_drop_cnt_o}, 32'd3);
    step("fl_idle", 0, 0, 0, 1, 0, STL);
    step("fl_idle_flush_v", 1, 1, 0, 1, 0, STL);
    chk("fl_idle_dcnt", {16'd0, pkt_drop_cnt_o}, 32'd3);
    step("fl_next", 1, 1, 0, 0, 0, CMT);
    chk("fl_ccnt", {16'd0, pkt_commit_cnt_o}, 32'd4);

    // reset mid-packet clears beat count and counters, no drop
    step("rst_b1", 1, 0, 0, 0, 0, ENQ);
    step("rst_b2", 1, 0, 0, 0, 0, ENQ);
    reset_i = 1'b1;
    @(posedge clk); #1; reset_i = 1'b0;
    chk("rst_ccnt", {16'd0, pkt_commit_cnt_o}, 32'd0);
    chk("rst_dcnt", {16'd0, pkt_drop_cnt_o}, 32'd0);
    step("rst_p_b1", 1, 0, 0, 0, 0, ENQ);
    step("rst_p_b2", 1, 0, 0, 0, 0, ENQ);
    step("rst_p_b3", 1, 0, 0, 0, 0, ENQ);
    step("rst_p_b4", 1, 1, 0, 0, 0, CMT);
    chk("rst_p_ccnt", {16'd0, pkt_commit_cnt_o}, 32'd1);

    // back-to-back single-beat packets up to saturation
    bad = 0;
    bus.v_i = 1'b1; bus.last_i = 1'b1; bus.err_i = 1'b0; full_i = 1'b0; flush_i = 1'b0;
    for (int i = 0; i < 65533; i++) begin
      @(negedge clk);
      if (!(enq_o && commit_o && !drop_o && bus.ready_o)) bad++;
      @(posedge clk); #1;
    end
    chk("b2b_ccnt_fffe", {16'd0, pkt_commit_cnt_o}, 32'hFFFE);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!(enq_o && commit_o && !drop_o && bus.ready_o)) bad++;
      @(posedge clk); #1;
    end
    chk("b2b_every_cycle", bad, 32'd0);
    chk("b2b_ccnt_sat", {16'd0, pkt_commit_cnt_o}, 32'hFFFF);

    // random stimulus, invariants
    v1 = 0; v2 = 0; v3 = 0;
    for (int i = 0; i < 2000; i++) begin
      bus.v_i = 1'($urandom_range(0, 3) != 0);
      bus.last_i = 1'($urandom_range(0, 3) == 0);
      bus.err_i = 1'($urandom_range(0, 15) == 0);
      bus.data_i = 8'($urandom);
      flush_i = 1'($urandom_range(0, 15) == 0);
      full_i = 1'($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (commit_o && drop_o) v1++;
      if (drop_o && enq_o) v2++;
      if (enq_o && full_i) v3++;
      @(posedge clk); #1;
    end
    bus.v_i = 1'b0; flush_i = 1'b0; full_i = 1'b0;
    chk("rnd_commit_and_drop", v1, 32'd0);
    chk("rnd_drop_with_enq", v2, 32'd0);
    chk("rnd_enq_while_full", v3, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
